// File: rtl/dest_control.sv
// Read-side controller of the dual-clock FIFO: synchronises the write pointer into
// clk_d and streams stored words out on a registered valid/ready port. Optional macro: DEST_UNDERFLOW_CNT_EN.
module dest_control #(
    parameter int DATA_WIDTH  = 8,
    parameter int PTR_WIDTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_d,
    input  logic                  rst_d,
    input  logic [PTR_WIDTH-1:0]  write_pointer,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  dout_ready,
    output logic [PTR_WIDTH-1:0]  read_pointer,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic [PTR_WIDTH-1:0]  level
`ifdef DEST_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]            underflow_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FLOW = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t                  state_reg, state_next;
    logic [PTR_WIDTH-1:0]    rp_reg, rp_next;
    logic [DATA_WIDTH-1:0]   dout_reg, dout_next;
    logic [PTR_WIDTH-1:0]    wp_s;
    logic                    valid;
    logic                    load;

    // Write-pointer synchroniser; each stage lives in its own generate scope.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [PTR_WIDTH-1:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_d) begin
                    if (rst_d) stage_reg <= '0;
                    else       stage_reg <= write_pointer;
                end
            end else begin : g_next
                always_ff @(posedge clk_d) begin
                    if (rst_d) stage_reg <= '0;
                    else       stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign wp_s  = g_sync[SYNC_STAGES-1].stage_reg;
    // Modulo subtraction handles pointer wrap; a stale wp_s only under-reports.
    assign level = wp_s - rp_reg;
    assign empty = rst_d || (level == '0);
    assign valid = (state_reg != IDLE);
    assign load  = !empty && (!valid || dout_ready);

    always_comb begin
        state_next = state_reg;
        rp_next    = rp_reg;
        dout_next  = dout_reg;
        if (load) begin
            // Accept-and-reload in one cycle keeps valid high with no bubble.
            dout_next  = mem_data;
            rp_next    = rp_reg + PTR_WIDTH'(1);
            state_next = dout_ready ? FLOW : HOLD;
        end else if (valid && dout_ready) begin
            state_next = IDLE;
        end else if (valid) begin
            state_next = HOLD;
        end
    end

    always_ff @(posedge clk_d) begin
        if (rst_d) begin
            state_reg <= IDLE;
            rp_reg    <= '0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            rp_reg    <= rp_next;
            dout_reg  <= dout_next;
        end
    end

    assign read_pointer = rp_reg;
    assign dout         = dout_reg;
    assign dout_valid   = valid;

`ifdef DEST_UNDERFLOW_CNT_EN
    // Counts cycles where downstream was ready but nothing was offered.
    logic [7:0] underflow_cnt_reg;

    always_ff @(posedge clk_d) begin
        if (rst_d)
            underflow_cnt_reg <= '0;
        else if (dout_ready && !valid && (underflow_cnt_reg != 8'hFF))
            underflow_cnt_reg <= underflow_cnt_reg + 8'd1;
    end

    assign underflow_cnt = underflow_cnt_reg;
`endif

endmodule

// File: doc/dest_control.md
Name: dest_control

Overview:
- Read-side (destination-domain) controller of the dual-clock asynchronous FIFO.
- Runs on clk_d and synchronises the source-domain write pointer.
- Fetches entries from the shared 8-entry storage at read_pointer and presents them on a registered valid/ready output.
- Returns read_pointer to the source-side controller, which uses it for its occupancy check.

Parameters:
- DATA_WIDTH, 8, width of stored words and dout.
- PTR_WIDTH, 3, pointer width; storage depth is 2**PTR_WIDTH = 8.
- SYNC_STAGES, 2, flop stages on the incoming write_pointer; legal values 2..4.

Ports:
- clk_d  input  1  destination-domain clock.
- rst_d  input  1  synchronous, active-high reset.
- write_pointer  input  PTR_WIDTH  write pointer from the source domain; asynchronous to clk_d.
- mem_data  input  DATA_WIDTH  storage word at address read_pointer (combinational read).
- dout_ready  input  1  downstream accepts dout this cycle.
- read_pointer  output  PTR_WIDTH  registered read address; also fed back to the source domain.
- dout  output  DATA_WIDTH  registered output data.
- dout_valid  output  1  dout holds a valid word.
- empty  output  1  no unread entry per the synchronised view.
- level  output  PTR_WIDTH  synchronised occupancy.
- underflow_cnt  output  8  present only with the optional feature.

Behaviour:
- Reset (rst_d=1 at a clk_d edge) sets every register and output to 0: sync chain, read_pointer, dout, dout_valid, state, underflow_cnt. empty=1 while in reset.
- Reset mid-transfer discards any held word without handshake.
- Sync chain: wp_sync[0] <= write_pointer, then wp_sync[i] <= wp_sync[i-1]. wp_s = last stage.
- A write_pointer change is visible in wp_s after SYNC_STAGES edges.
- level = wp_s - read_pointer, computed modulo 2**PTR_WIDTH (pointers wrap 7->0). empty = (level==0). Both are combinational from registers.
- State machine, 2 bits:
  - IDLE: dout_valid=0.
  - FLOW: dout_valid=1 and the word is being accepted.
  - HOLD: dout_valid=1 and dout_ready=0.
- Load condition: load = !empty && (!dout_valid || dout_ready).
- On load:
  - dout <= mem_data.
  - dout_valid <= 1.
  - read_pointer <= read_pointer+1 (wrap 7->0).
  - state <= FLOW if dout_ready, else HOLD.
- Else if dout_valid && dout_ready: dout_valid <= 0, state <= IDLE.
- Else if dout_valid && !dout_ready: dout, dout_valid and read_pointer hold; state <= HOLD.
- Throughput is one word per clk_d while !empty and dout_ready=1.
- Latency: first write visible at write_pointer produces dout_valid=1 after SYNC_STAGES+1 clk_d edges.
- Simultaneous accept and load in the same cycle: the new word replaces the old one, dout_valid stays 1, and no bubble is inserted.
- read_pointer never advances when empty=1. A stale wp_s can only under-report occupancy, never over-report it.
- level never exceeds 6 in legal operation, because the source side stops at occupancy 6. level 7 is passed through unchanged and not flagged.
- In HOLD, dout stays stable regardless of mem_data changes.

Optional Feature:
- Macro: DEST_UNDERFLOW_CNT_EN.
- Defined:
  - 8-bit underflow_cnt port exists.
  - Increments each clk_d with dout_ready=1 and dout_valid=0, saturating at 255.
  - Cleared by rst_d.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_d 2 cycles with write_pointer=5 -> read_pointer=0, dout_valid=0, empty=1, level=0. After release, level=5 by the SYNC_STAGES-th edge.
- Single word: write_pointer 0->1, mem_data=8'hA5, dout_ready=1 -> dout=A5 and dout_valid=1 on edge 3, then 0 the next cycle; read_pointer=1.
- Back-to-back: write_pointer=6, storage holds 10..15, dout_ready=1 -> six consecutive valid cycles with dout=10..15; read_pointer=6, empty=1.
- Backpressure: 3 words pending, dout_ready=0 for 5 cycles -> dout holds the first word, read_pointer advanced by 1 only, state HOLD. Releasing ready drains the remaining 2 words with no gaps.
- Wrap: start read_pointer=6, write_pointer 6->2 -> words read at addresses 6,7,0,1; read_pointer ends at 2; level passes 4->0.
- With DEST_UNDERFLOW_CNT_EN: dout_ready=1, empty for 300 cycles -> underflow_cnt=255. Reset -> 0.
